// File: rtl/blake_pkg.sv
// Shared constants for the blake_64 host adapter: word/block/digest geometry and control states.
package blake_pkg;

  localparam int unsigned W         = 64;
  localparam int unsigned IN_WORDS  = 10;
  localparam int unsigned OUT_WORDS = 8;
  localparam int unsigned BLOCK_W   = W * IN_WORDS;
  localparam int unsigned DIGEST_W  = W * OUT_WORDS;
  localparam int unsigned CNT_W     = 16;
  localparam int unsigned IN_IDX_W  = 4;
  localparam int unsigned OUT_IDX_W = 3;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

endpackage

// File: rtl/blake_digest_ser.sv
// Holds one 512-bit digest and streams it out as eight 64-bit beats, most significant word first.
module blake_digest_ser
  import blake_pkg::*;
(
  input  logic                clk,
  input  logic                rstb,
  input  logic                load,
  input  logic [DIGEST_W-1:0] din,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [W-1:0]        m_data,
  output logic                m_last,
  output logic [CNT_W-1:0]    blocks_done
);

  logic [DIGEST_W-1:0]  out_buf;
  logic [OUT_IDX_W-1:0] out_idx;
  logic                 out_full;
  logic                 last_q;
  logic [CNT_W-1:0]     done_cnt;
  logic                 m_hs;
  logic                 at_last;

  assign m_hs    = out_full && m_ready;
  assign at_last = (out_idx == OUT_IDX_W'(OUT_WORDS - 1));

  // Shift the buffer so the current beat always sits in the top word.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      out_buf  <= '0;
      out_idx  <= '0;
      out_full <= 1'b0;
      last_q   <= 1'b0;
      done_cnt <= '0;
    end else if (load) begin
      out_buf  <= din;
      out_idx  <= '0;
      out_full <= 1'b1;
      last_q   <= 1'b0;
    end else if (m_hs) begin
      if (at_last) begin
        out_full <= 1'b0;
        out_idx  <= '0;
        last_q   <= 1'b0;
        done_cnt <= done_cnt + CNT_W'(1);
      end else begin
        out_buf <= {out_buf[DIGEST_W-W-1:0], {W{1'b0}}};
        out_idx <= out_idx + OUT_IDX_W'(1);
        last_q  <= (out_idx == OUT_IDX_W'(OUT_WORDS - 2));
      end
    end
  end

  assign m_valid     = out_full;
  assign m_data      = out_buf[DIGEST_W-1 -: W];
  assign m_last      = last_q;
  assign blocks_done = done_cnt;

endmodule

// File: rtl/blake_host_if.sv
// Host adapter for blake_64: stages ten input words, launches the core, and hands the digest to the serializer.
module blake_host_if
  import blake_pkg::*;
(
  input  logic               clk,
  input  logic               rstb,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [W-1:0]       s_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [W-1:0]       m_data,
  output logic               m_last,
  output logic               core_ena,
  output logic [BLOCK_W-1:0] core_din,
  input  logic               core_rdy,
  input  logic [DIGEST_W-1:0] core_dout,
  output logic               busy,
  output logic [CNT_W-1:0]   blocks_done,
  output logic               err_spurious
);

  logic [0:0]          state_q;
  logic [0:0]          state_d;
  logic                launch_c;
  logic                load_c;
  logic [BLOCK_W-1:0]  stage;
  logic [BLOCK_W-1:0]  launch_din;
  logic [IN_IDX_W-1:0] in_idx;
  logic                staged_full;
  logic                staged_full_d;
  logic                s_ready_q;
  logic                core_ena_q;
  logic                err_q;
  logic                s_hs;
  logic                in_last;

  assign s_hs    = s_valid && s_ready_q;
  assign in_last = (in_idx == IN_IDX_W'(IN_WORDS - 1));
  assign load_c  = core_rdy && (state_q == ST_BUSY);

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Launch waits for the output side to be empty so core_rdy never meets a full digest buffer.
  always_comb begin
    state_d  = state_q;
    launch_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (staged_full && !m_valid) begin
          launch_c = 1'b1;
          state_d  = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (core_rdy) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    staged_full_d = staged_full;
    if (launch_c)             staged_full_d = 1'b0;
    else if (s_hs && in_last) staged_full_d = 1'b1;
  end

  // Stage shifts in from the bottom, so after ten beats word 0 ends up most significant.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      stage       <= '0;
      launch_din  <= '0;
      in_idx      <= '0;
      staged_full <= 1'b0;
      s_ready_q   <= 1'b0;
      core_ena_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      staged_full <= staged_full_d;
      s_ready_q   <= ~staged_full_d;
      core_ena_q  <= launch_c;
      if (s_hs) begin
        stage  <= {stage[BLOCK_W-W-1:0], s_data};
        in_idx <= in_last ? '0 : in_idx + IN_IDX_W'(1);
      end
      if (launch_c) launch_din <= stage;
      if (core_rdy && (state_q == ST_IDLE)) err_q <= 1'b1;
    end
  end

  blake_digest_ser u_ser (
    .clk         (clk),
    .rstb        (rstb),
    .load        (load_c),
    .din         (core_dout),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .m_last      (m_last),
    .blocks_done (blocks_done)
  );

  assign s_ready      = s_ready_q;
  assign core_ena     = core_ena_q;
  assign core_din     = launch_din;
  assign busy         = (state_q == ST_BUSY);
  assign err_spurious = err_q;

endmodule

// File: tb/tb_blake_host_if.sv
// Scoreboard bench for blake_host_if with a behavioural blake_64 core model.
module tb_blake_host_if;

  localparam int LAT = 40;

  logic          clk;
  logic          rstb;
  logic          s_valid;
  logic          s_ready;
  logic [63:0]   s_data;
  logic          m_valid;
  logic          m_ready;
  logic [63:0]   m_data;
  logic          m_last;
  logic          core_ena;
  logic [639:0]  core_din;
  logic          core_rdy;
  logic [511:0]  core_dout;
  logic          busy;
  logic [15:0]   blocks_done;
  logic          err_spurious;

  blake_host_if dut (
    .clk(clk), .rstb(rstb),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .core_ena(core_ena), .core_din(core_din), .core_rdy(core_rdy), .core_dout(core_dout),
    .busy(busy), .blocks_done(blocks_done), .err_spurious(err_spurious)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [639:0] din_q[$];
  logic [64:0]  exp_q[$];
  logic [15:0]  exp_done = '0;

  logic         pend = 0;
  logic         ena_prev = 0;
  logic         rdy_chk = 0;
  logic         spur_req = 0;
  logic         lat_chk = 0;
  int           cnt = 0;
  int           blk_n = 0;
  int           beat9_cyc = 0;
  logic [639:0] cap;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [639:0] act, input logic [639:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s act=timeout_or_unexpected exp=event", name);
  endtask

  task automatic slot();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [511:0] mk_dout(input int n);
    logic [511:0] d = '0;
    for (int i = 0; i < 8; i++) d = {d[447:0], 64'hA0 + 64'(i) + 64'(n) * 64'h100};
    return d;
  endfunction

  // Behavioural core: rdy LAT cycles after ena, checks launch rules, feeds the scoreboard.
  initial begin
    logic [511:0] d;
    logic ena_now;
    core_rdy = 0;
    core_dout = '0;
    forever begin
      slot();
      ena_now = 0;
      if (!rstb) begin
        pend = 0; ena_prev = 0; rdy_chk = 0; core_rdy = 0;
      end else begin
        core_rdy = 0;
        if (rdy_chk) begin
          chk("rdy_to_valid", 640'(m_valid), 640'(1));
          rdy_chk = 0;
        end
        if (ena_prev) begin
          chk("ena_width", 640'(core_ena), 640'(0));
          ena_prev = 0;
        end else if (core_ena) begin
          ena_prev = 1;
          ena_now = 1;
          chk("launch_after_drain", 640'({m_valid, exp_q.size() == 0}), 640'(2'b01));
          chk("busy_on_launch", 640'(busy), 640'(1));
          if (din_q.size() == 0) fail_now("unexpected_launch");
          else chk("core_din", core_din, din_q.pop_front());
          if (lat_chk) begin
            chk("ena_latency", 640'(cyc - beat9_cyc), 640'(2));
            chk("din_msw", 640'(core_din[639:576]), 640'(0));
            chk("din_lsw", 640'(core_din[63:0]), 640'(9));
            lat_chk = 0;
          end
          cap = core_din;
          pend = 1;
          cnt = LAT;
        end
        if (pend && !ena_now) begin
          cnt--;
          if (cnt == 0) begin
            chk("din_hold", core_din, cap);
            d = mk_dout(blk_n);
            core_rdy = 1;
            core_dout = d;
            for (int i = 0; i < 8; i++) exp_q.push_back({i == 7, d[511-64*i -: 64]});
            blk_n++;
            pend = 0;
            rdy_chk = 1;
          end
        end else if (spur_req && !pend && !ena_now) begin
          core_rdy = 1;
          core_dout = {8{64'hDEAD_BEEF_0BAD_F00D}};
          spur_req = 0;
        end
      end
    end
  end

  // Output monitor: pops the scoreboard on every handshake and checks stall stability.
  initial begin
    logic [64:0] e;
    logic        stall_prev = 0;
    logic [63:0] stall_data = '0;
    logic        done_chk = 0;
    forever begin
      @(negedge clk);
      if (done_chk) begin
        chk("blocks_done", 640'(blocks_done), 640'(exp_done));
        done_chk = 0;
      end
      if (rstb) begin
        if (stall_prev) chk("stall_hold", 640'({m_valid, m_data}), 640'({1'b1, stall_data}));
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) fail_now("unexpected_beat");
          else begin
            e = exp_q.pop_front();
            chk("m_beat", 640'({m_last, m_data}), 640'(e));
            if (e[64]) begin
              exp_done = exp_done + 16'd1;
              done_chk = 1;
            end
          end
        end
        stall_prev = m_valid && !m_ready;
        stall_data = m_data;
      end else begin
        stall_prev = 0;
      end
    end
  end

  task automatic send_word(input logic [63:0] w, input logic is_last);
    int g = 0;
    s_valid = 1;
    s_data = w;
    while (!s_ready && g < 2000) begin
      slot();
      g++;
    end
    if (!s_ready) fail_now("s_ready_wait");
    if (is_last) beat9_cyc = cyc;
    slot();
  endtask

  task automatic send_block(input logic [63:0] base);
    logic [639:0] blk = '0;
    for (int i = 0; i < 10; i++) blk = {blk[575:0], base + 64'(i)};
    din_q.push_back(blk);
    for (int i = 0; i < 10; i++) send_word(base + 64'(i), i == 9);
    s_valid = 0;
  endtask

  task automatic wait_drained();
    int g = 0;
    while (!(din_q.size() == 0 && !pend && exp_q.size() == 0 && !m_valid && !busy && !core_ena)
           && g < 3000) begin
      slot();
      g++;
    end
    if (g >= 3000) fail_now("drain_timeout");
    slot();
    slot();
  endtask

  task automatic reset_check(input string tag);
    chk({tag, "_ctl"}, 640'({s_ready, m_valid, m_last, core_ena, busy, err_spurious}), 640'(0));
    chk({tag, "_m_data"}, 640'(m_data), 640'(0));
    chk({tag, "_core_din"}, core_din, 640'(0));
    chk({tag, "_blocks_done"}, 640'(blocks_done), 640'(0));
  endtask

  initial begin
    int g;
    rstb = 0;
    s_valid = 0;
    s_data = '0;
    m_ready = 1;
    #2;
    reset_check("por");
    repeat (3) slot();
    rstb = 1;
    slot();

    // Basic block: words 0..9, digest A0..A7.
    lat_chk = 1;
    send_block(64'h0);
    wait_drained();
    chk("basic_done", 640'(blocks_done), 640'(1));

    // Output backpressure.
    m_ready = 0;
    send_block(64'h10);
    g = 0;
    while (!m_valid && g < 500) begin slot(); g++; end
    if (!m_valid) fail_now("m_valid_wait");
    repeat (20) slot();
    g = 0;
    while ((exp_q.size() != 0 || m_valid) && g < 200) begin
      m_ready = ~m_ready;
      slot();
      g++;
    end
    m_ready = 1;
    wait_drained();

    // Overlap: B staged while A hashes, held until A has drained.
    send_block(64'h20);
    send_block(64'h30);
    chk("overlap_s_ready", 640'({s_ready, busy}), 640'(2'b01));
    wait_drained();

    // Spurious completion.
    spur_req = 1;
    repeat (3) slot();
    chk("spur_err", 640'(err_spurious), 640'(1));
    chk("spur_m_valid", 640'(m_valid), 640'(0));
    chk("spur_done", 640'(blocks_done), 640'(exp_done));
    repeat (10) slot();
    send_block(64'h60);
    wait_drained();
    chk("spur_sticky", 640'(err_spurious), 640'(1));

    // Reset after 5 beats of a partial block.
    for (int i = 0; i < 5; i++) send_word(64'hF0 + 64'(i), 1'b0);
    s_valid = 0;
    rstb = 0;
    #1;
    reset_check("rst_partial");
    din_q.delete();
    exp_q.delete();
    exp_done = '0;
    repeat (2) slot();
    rstb = 1;
    slot();

    // Reset while hashing.
    send_block(64'h40);
    g = 0;
    while (!pend && g < 100) begin slot(); g++; end
    if (!pend) fail_now("launch_wait");
    repeat (5) slot();
    rstb = 0;
    #1;
    reset_check("rst_busy");
    din_q.delete();
    exp_q.delete();
    exp_done = '0;
    repeat (2) slot();
    rstb = 1;
    slot();
    send_block(64'h50);
    wait_drained();
    chk("post_rst_done", 640'(blocks_done), 640'(1));

    // Counter wrap from a preloaded value.
    force dut.u_ser.done_cnt = 16'hFFFE;
    slot();
    release dut.u_ser.done_cnt;
    exp_done = 16'hFFFE;
    slot();
    chk("preload", 640'(blocks_done), 640'(16'hFFFE));
    send_block(64'h70);
    wait_drained();
    chk("wrap_ffff", 640'(blocks_done), 640'(16'hFFFF));
    send_block(64'h80);
    wait_drained();
    chk("wrap_0000", 640'(blocks_done), 640'(16'h0000));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/blake_host_if.md
Name: blake_host_if

Overview:
- Host-side stream adapter that drives the blake_64 hashing core.
- Collects ten 64-bit input words into a 640-bit block and launches the core with a one-cycle `core_ena` pulse.
- Captures the 512-bit digest on `core_rdy` and serializes it as eight 64-bit words on a valid/ready output stream.
- Double-buffers the input side: the next block can be loaded while the core is hashing or the output is draining.

Parameters:
- W, 64, word width (fixed; shown for readability).
- IN_WORDS, 10, input beats per block; core_din width = W*IN_WORDS = 640.
- OUT_WORDS, 8, output beats per digest; core_dout width = W*OUT_WORDS = 512.
- CNT_W, 16, width of blocks_done counter.

Ports:
- clk  in  1  clock
- rstb  in  1  asynchronous active-low reset
- s_valid  in  1  input word valid
- s_ready  out  1  input word accepted when s_valid && s_ready
- s_data  in  64  input word; beat 0 = most significant word
- m_valid  out  1  digest word valid
- m_ready  in  1  downstream accepts digest word
- m_data  out  64  digest word; beat 0 = most significant word
- m_last  out  1  high on beat OUT_WORDS-1
- core_ena  out  1  one-cycle launch pulse to blake_64 ena
- core_din  out  640  block to blake_64 din; held stable from launch until core_rdy
- core_rdy  in  1  one-cycle completion pulse from blake_64 rdy
- core_dout  in  512  digest from blake_64 dout; valid in the core_rdy cycle
- busy  out  1  core is hashing (between launch and core_rdy)
- blocks_done  out  CNT_W  digests fully delivered; wraps modulo 2^CNT_W
- err_spurious  out  1  sticky: core_rdy seen while not busy

Behaviour:
- Reset (async, rstb=0): all outputs 0; stage/launch/out buffers 0; all counters and flags 0. Reset mid-operation discards any partial or in-flight block; the core shares rstb.
- Input staging:
  - s_ready = ~staged_full.
  - On each handshake, write stage word in_idx into bits [639-64*in_idx -: 64], then increment in_idx.
  - On the handshake with in_idx == IN_WORDS-1: set staged_full and reset in_idx to 0.
  - No byte swapping here; the core does its own swapping.
- Launch condition (registered flags): staged_full && !busy && !out_full.
  - At clock edge T with the condition true: launch_din <= stage; staged_full <= 0; busy <= 1; core_ena <= 1.
  - core_ena is high for exactly cycle T+1, then 0. core_din = launch_din at all times.
  - s_ready rises at T+1, so the next block can load during hashing.
- Completion: core_rdy && busy:
  - busy <= 0; out_buf <= core_dout; out_full <= 1; out_idx <= 0.
- Spurious completion: core_rdy && !busy:
  - Ignored; err_spurious <= 1 (cleared only by reset).
- Output:
  - m_valid = out_full; m_data = out_buf[511-64*out_idx -: 64]; m_last = out_full && (out_idx == OUT_WORDS-1).
  - On handshake: out_idx++.
  - On the last-beat handshake: out_full <= 0, out_idx <= 0, blocks_done <= blocks_done+1 (wraps 0xFFFF -> 0x0000).
- Simultaneous events:
  - Last input handshake and launch in the same cycle cannot collide, because launch uses the registered staged_full.
  - Last output handshake clears out_full; a pending launch occurs on the following edge (1-cycle bubble, by design).
  - core_rdy cannot coincide with out_full=1, because launch requires !out_full.
- m_valid stays asserted and m_data stays stable while m_ready=0.
- Maximum blocks in flight: 1 staged + 1 hashing. Output holds one digest.
- Latency:
  - Last input beat to core_ena: 2 cycles when idle.
  - core_rdy to first m_valid: 1 cycle.

Decomposition:
- Shared package blake_pkg: W, IN_WORDS, OUT_WORDS, block/digest width constants, and the FSM state enum {IDLE, BUSY} if encoded explicitly.
- One natural sub-module: blake_digest_ser (out_buf, out_idx, m_* handshake, blocks_done).
- Input staging and launch control remain in the top.

Test Plan:
- Basic block:
  - Stimulus: feed words 0x0..0x9 back-to-back; core model asserts rdy 40 cycles after ena with dout = {8 words 0xA0..0xA7}.
  - Required: core_din[639:576]=0x0 and core_din[63:0]=0x9; core_ena high for exactly 1 cycle, 2 cycles after beat 9.
  - Required: m_data sequence 0xA0..0xA7 with m_last only on 0xA7; blocks_done=1.
- Output backpressure:
  - Stimulus: hold m_ready=0 for 20 cycles after m_valid rises, then toggle m_ready 1/0.
  - Required: m_data stable while stalled; each of the 8 words delivered exactly once, in order.
- Overlap:
  - Stimulus: send block B while block A is hashing.
  - Required: s_ready drops after B's 10th beat; B launches only after A's last output beat (out_full=0).
  - Required: core_din is unchanged between A's launch and A's core_rdy.
- Spurious rdy:
  - Stimulus: pulse core_rdy while busy=0.
  - Required: err_spurious=1 and sticky; m_valid stays 0; blocks_done unchanged.
- Reset mid-operation:
  - Stimulus: deassert rstb after 5 input beats and again while busy.
  - Required: all outputs 0 immediately.
  - Required: after release, a fresh 10-beat block hashes correctly with no leftover words.
- Counter wrap:
  - Stimulus: force or run 65536 blocks.
  - Required: blocks_done goes 0xFFFF -> 0x0000 on the last beat of the next digest.
